fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 10 +
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_if_id_reg.sv | 18 +
 rtl/fetch_unit.sv | 55 +++++
 tb/tb_fetch_unit.sv | 135 +++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared front-end constants (XLEN, NOP, reset PC), FSM state encoding and PC alignment helper
package fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory bus (req/addr from fetch, ready/rdata from memory); master = fetch side, slave = memory side
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  logic req;
  logic [XLEN-1:0] addr;
  logic ready;
  logic [XLEN-1:0] rdata;
  modport master(output req, addr, input ready, rdata);
  modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// fetch_unit_if_id_reg: IF/ID pipeline register; in clk/rst/load/flush/pc_in/instr_in, out pc/instr/valid; holds when neither load nor flush
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            valid
);
  always_ff @(posedge clk)
    if (rst || flush) {pc, instr, valid} <= {{XLEN{1'b0}}, NOP, 1'b0};
    else if (load) {pc, instr, valid} <= {pc_in, instr_in, 1'b1};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, fetch FSM and skid buffer; in clk/rst/stall_id/mem_stall/redirect/redirect_pc, imem master bus, out IF/ID id_pc/id_instr/id_valid
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_id,
  input  logic             mem_stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  fetch_unit_if.master     imem,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_instr,
  output logic             id_valid
);
  state_t state, state_d;
  logic hold, redir, load, flush;
  logic [XLEN-1:0] pc, drop_addr, skid;
  assign hold = stall_id | mem_stall;
  assign redir = redirect & ~mem_stall;
  always_ff @(posedge clk) state <= rst ? FETCH : state_d;
  always_comb begin
    state_d = state;
    if (redir) state_d = (state != HOLD && !imem.ready) ? DROP : FETCH;
    else if (state == DROP) state_d = imem.ready ? FETCH : DROP;
    else if (state == FETCH && imem.ready && hold) state_d = HOLD;
    else if (state == HOLD && !hold) state_d = FETCH;
  end
  always_comb begin
    imem.req = ~rst & (state != HOLD);
    imem.addr = state == DROP ? drop_addr : pc;
    load = ~redir & ~hold & (state == HOLD | (state == FETCH & imem.ready));
    flush = redir | (~hold & (state == DROP | (state == FETCH & ~imem.ready)));
  end
  always_ff @(posedge clk) begin
    if (rst) pc <= align(RESET_PC);
    else if (redir) pc <= align(redirect_pc);
    else if (load) pc <= pc + 32'd4;
    if (redir && state == FETCH && !imem.ready) drop_addr <= pc;
    if (state == FETCH && imem.ready && hold && !redir) skid <= imem.rdata;
  end
  fetch_unit_if_id_reg u_if_id (
    .clk(clk),
    .rst(rst),
    .load(load),
    .flush(flush),
    .pc_in(pc),
    .instr_in(state == HOLD ? skid : imem.rdata),
    .pc(id_pc),
    .instr(id_instr),
    .valid(id_valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, stall_id, mem_stall, redirect, rdy;
  logic [31:0] redirect_pc, id_pc, id_instr;
  logic id_valid;
  int checks = 0;
  int errors = 0;
  fetch_unit_if bus();
  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall_id(stall_id),
    .mem_stall(mem_stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem(bus),
    .id_pc(id_pc),
    .id_instr(id_instr),
    .id_valid(id_valid)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hABCD_0000;
  endfunction
  assign bus.ready = rdy & bus.req;
  assign bus.rdata = word(bus.addr);
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; stall_id = 0; mem_stall = 0; redirect = 0; rdy = 1; redirect_pc = 0;
    tick;
    check("rst_req", {31'b0, bus.req}, 0);
    check("rst_valid", {31'b0, id_valid}, 0);
    check("rst_instr", id_instr, 32'h13);
    check("rst_pc", id_pc, 0);
    rst = 0;
    #1;
    check("first_req", {31'b0, bus.req}, 1);
    check("first_addr", bus.addr, 0);
    tick;
    check("first_valid", {31'b0, id_valid}, 1);
    check("first_instr", id_instr, word(0));
    for (int i = 1; i <= 4; i++) begin
      tick;
      check("stream_pc", id_pc, 32'(4 * i));
      check("stream_valid", {31'b0, id_valid}, 1);
    end
    stall_id = 1;
    tick;
    check("hold1_pc", id_pc, 16);
    check("hold1_req", {31'b0, bus.req}, 0);
    tick;
    check("hold2_pc", id_pc, 16);
    check("hold2_req", {31'b0, bus.req}, 0);
    stall_id = 0;
    tick;
    check("skid_pc", id_pc, 20);
    check("skid_instr", id_instr, word(20));
    check("skid_addr", bus.addr, 24);
    tick;
    check("after_skid_pc", id_pc, 24);
    redirect = 1; redirect_pc = 32'h103; stall_id = 1;
    tick;
    check("redir_valid", {31'b0, id_valid}, 0);
    check("redir_instr", id_instr, 32'h13);
    redirect = 0; stall_id = 0;
    #1;
    check("redir_addr", bus.addr, 32'h100);
    tick;
    check("redir_id_pc", id_pc, 32'h100);
    rdy = 0;
    tick;
    check("wait_bubble", {31'b0, id_valid}, 0);
    check("wait_addr", bus.addr, 32'h104);
    redirect = 1; redirect_pc = 32'h200;
    tick;
    redirect = 0;
    #1;
    check("drop_addr", bus.addr, 32'h104);
    check("drop_req", {31'b0, bus.req}, 1);
    tick;
    check("drop_addr2", bus.addr, 32'h104);
    check("drop_valid", {31'b0, id_valid}, 0);
    rdy = 1;
    tick;
    check("drop_done_valid", {31'b0, id_valid}, 0);
    check("drop_done_addr", bus.addr, 32'h200);
    tick;
    check("target_pc", id_pc, 32'h200);
    check("target_instr", id_instr, word(32'h200));
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 0;
    #1;
    check("top_addr", bus.addr, 32'hFFFF_FFFC);
    tick;
    check("wrap_addr", bus.addr, 0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    mem_stall = 1; redirect = 1; redirect_pc = 32'h300;
    tick;
    check("mstall_pc", id_pc, 32'hFFFF_FFFC);
    check("mstall_valid", {31'b0, id_valid}, 1);
    check("mstall_req", {31'b0, bus.req}, 0);
    mem_stall = 0;
    tick;
    redirect = 0;
    #1;
    check("late_redir_valid", {31'b0, id_valid}, 0);
    check("late_redir_addr", bus.addr, 32'h300);
    rdy = 0;
    tick;
    check("pre_rst_req", {31'b0, bus.req}, 1);
    rst = 1;
    tick;
    check("midrst_req", {31'b0, bus.req}, 0);
    check("midrst_valid", {31'b0, id_valid}, 0);
    check("midrst_instr", id_instr, 32'h13);
    rst = 0;
    #1;
    check("post_rst_req", {31'b0, bus.req}, 1);
    check("post_rst_addr", bus.addr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
